// File: rtl/wishbone_2mst_arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM encoding, bus widths, request bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wishbone_2mst_arbiter_pkg;

   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   // Read data handed back when the watchdog terminates a hung access
   localparam logic [WB_DAT_W-1:0] WB_ERR_DATA = 32'hDEAD_BEEF;

   // Encoding doubles as the one-hot grant vector (IDLE = 00)
   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_OWN0 = 2'b01,
      ARB_OWN1 = 2'b10
   } arb_state_t;

   // One master's request side of the bus
   typedef struct packed {
      logic                cyc;
      logic                stb;
      logic                we;
      logic [WB_ADR_W-1:0] adr;
      logic [WB_DAT_W-1:0] dat;
      logic [WB_SEL_W-1:0] sel;
   } wb_req_t;

   // Owner chosen from IDLE: a lone requester wins, a tie goes to whoever did not own last
   function automatic arb_state_t arb_pick(input logic cyc0, input logic cyc1, input logic last_owner);
      arb_state_t pick;
      pick = ARB_IDLE;
      if (cyc0 && cyc1) begin
         pick = last_owner ? ARB_OWN0 : ARB_OWN1;
      end else if (cyc0) begin
         pick = ARB_OWN0;
      end else if (cyc1) begin
         pick = ARB_OWN1;
      end
      return pick;
   endfunction

endpackage

// File: rtl/wishbone_2mst_arbiter_watchdog.sv
// Bus watchdog: counts STB-without-ACK cycles and fires to_hit on the last allowed cycle.
// Latency: to_hit is combinational in the cycle the count reaches TIMEOUT-1.
// Backpressure: none; a real ack in the same cycle always suppresses to_hit.
module wb_timeout_watchdog #(
   parameter int              TO_W    = 8,
   parameter logic [TO_W-1:0] TIMEOUT = 8'd255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic stb,
   input  logic ack,
   output logic to_hit
);

   // A zero TIMEOUT disables the watchdog entirely
   localparam logic            WD_EN   = (TIMEOUT != '0);
   localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

   logic [TO_W-1:0] count;

   assign to_hit = WD_EN && stb && !ack && (count == TO_LAST);

   // Count wait cycles of the current strobe; any ack, idle strobe, owner change or firing restarts it
   always_ff @(posedge clk) begin
      if (rst || clr || !WD_EN || !stb || ack || to_hit) begin
         count <= '0;
      end else begin
         count <= count + TO_W'(1);
      end
   end

endmodule

// File: rtl/wishbone_2mst_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between M0 (host) and M1 (sequencer).
// Latency: 1 cycle from cyc to grant; data/ack paths are combinational through the owner mux.
// Backpressure: non-owner is stalled (no ack) until the owner drops cyc; hung strobes are cut by the watchdog.
module wishbone_2mst_arbiter
   import wishbone_2mst_arbiter_pkg::*;
#(
   parameter int                  TO_W     = 8,
   parameter logic [TO_W-1:0]     TIMEOUT  = 8'd255,
   parameter logic [WB_DAT_W-1:0] ERR_DATA = WB_ERR_DATA
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,

   input  logic                wbs_m0_cyc_i,
   input  logic                wbs_m0_stb_i,
   input  logic                wbs_m0_we_i,
   input  logic [WB_ADR_W-1:0] wbs_m0_adr_i,
   input  logic [WB_DAT_W-1:0] wbs_m0_dat_i,
   input  logic [WB_SEL_W-1:0] wbs_m0_sel_i,
   output logic [WB_DAT_W-1:0] wbs_m0_dat_o,
   output logic                wbs_m0_ack_o,

   input  logic                wbs_m1_cyc_i,
   input  logic                wbs_m1_stb_i,
   input  logic                wbs_m1_we_i,
   input  logic [WB_ADR_W-1:0] wbs_m1_adr_i,
   input  logic [WB_DAT_W-1:0] wbs_m1_dat_i,
   input  logic [WB_SEL_W-1:0] wbs_m1_sel_i,
   output logic [WB_DAT_W-1:0] wbs_m1_dat_o,
   output logic                wbs_m1_ack_o,

   output logic                wbs_s_cyc_o,
   output logic                wbs_s_stb_o,
   output logic                wbs_s_we_o,
   output logic [WB_ADR_W-1:0] wbs_s_adr_o,
   output logic [WB_DAT_W-1:0] wbs_s_dat_o,
   output logic [WB_SEL_W-1:0] wbs_s_sel_o,
   input  logic [WB_DAT_W-1:0] wbs_s_dat_i,
   input  logic                wbs_s_ack_i,

   output logic [1:0]          grant_o,
   output logic                timeout_o
);

   arb_state_t          state;
   logic                last_owner;   // 0 = M0 owned last, 1 = M1 owned last
   wb_req_t             m0_req;
   wb_req_t             m1_req;
   wb_req_t             own_req;
   logic                own_stb;
   logic                owner_drop;
   logic                to_hit;
   logic                own_ack;
   logic [WB_DAT_W-1:0] own_dat;

   assign m0_req = '{cyc: wbs_m0_cyc_i, stb: wbs_m0_stb_i, we: wbs_m0_we_i,
                     adr: wbs_m0_adr_i, dat: wbs_m0_dat_i, sel: wbs_m0_sel_i};
   assign m1_req = '{cyc: wbs_m1_cyc_i, stb: wbs_m1_stb_i, we: wbs_m1_we_i,
                     adr: wbs_m1_adr_i, dat: wbs_m1_dat_i, sel: wbs_m1_sel_i};

   // Ownership FSM: lock the owner for its whole cycle, hand over without an idle bubble
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= ARB_IDLE;
         last_owner <= 1'b1;
      end else begin
         case (state)
            ARB_IDLE: begin
               state <= arb_pick(m0_req.cyc, m1_req.cyc, last_owner);
            end
            ARB_OWN0: begin
               if (!m0_req.cyc) begin
                  last_owner <= 1'b0;
                  state      <= m1_req.cyc ? ARB_OWN1 : ARB_IDLE;
               end
            end
            ARB_OWN1: begin
               if (!m1_req.cyc) begin
                  last_owner <= 1'b1;
                  state      <= m0_req.cyc ? ARB_OWN0 : ARB_IDLE;
               end
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   // Route the current owner's request to the slave side; nothing leaks through while idle
   always_comb begin
      own_req = '0;
      case (state)
         ARB_OWN0: own_req = m0_req;
         ARB_OWN1: own_req = m1_req;
         default:  own_req = '0;
      endcase
   end

   // Strobe only counts inside a live cycle, so an owner releasing cyc also clears the watchdog
   assign own_stb    = own_req.cyc & own_req.stb;
   assign owner_drop = ((state == ARB_OWN0) && !m0_req.cyc) ||
                       ((state == ARB_OWN1) && !m1_req.cyc);

   wb_timeout_watchdog #(
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .clr    (owner_drop),
      .stb    (own_stb),
      .ack    (wbs_s_ack_i),
      .to_hit (to_hit)
   );

   // Slave side: owner's request, with the strobe withdrawn on the cycle the watchdog terminates it
   assign wbs_s_cyc_o = own_req.cyc;
   assign wbs_s_stb_o = own_stb & ~to_hit;
   assign wbs_s_we_o  = own_req.we;
   assign wbs_s_adr_o = own_req.adr;
   assign wbs_s_dat_o = own_req.dat;
   assign wbs_s_sel_o = own_req.sel;

   // Return path: a stray ack after the owner let go of cyc is not forwarded
   assign own_ack = own_req.cyc & (wbs_s_ack_i | to_hit);
   assign own_dat = to_hit ? ERR_DATA : wbs_s_dat_i;

   assign wbs_m0_ack_o = (state == ARB_OWN0) & own_ack;
   assign wbs_m1_ack_o = (state == ARB_OWN1) & own_ack;
   assign wbs_m0_dat_o = (state == ARB_OWN0) ? own_dat : '0;
   assign wbs_m1_dat_o = (state == ARB_OWN1) ? own_dat : '0;

   assign grant_o   = state;
   assign timeout_o = to_hit;

endmodule

// File: tb/tb_wishbone_2mst_arbiter.sv
// Self-checking bench for wishbone_2mst_arbiter: directed vectors, scoreboarded acks.
// Latency: stimulus driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: a scripted slave model inserts wait states or never acks.
module tb_wishbone_2mst_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] m0_rdat, m1_rdat;
   logic        m0_ack, m1_ack;
   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_adr, s_wdat;
   logic [3:0]  s_sel;
   logic [31:0] s_rdat = 32'hCAFE_F00D;
   logic        s_ack  = 1'b0;
   logic [1:0]  grant;
   logic        tmo;

   // second instance with the watchdog disabled, driven only by nt_cyc on its M0
   logic        nt_cyc;
   logic [31:0] nt_m0_rdat, nt_m1_rdat, nt_s_adr, nt_s_wdat;
   logic        nt_m0_ack, nt_m1_ack, nt_s_cyc, nt_s_stb, nt_s_we, nt_tmo;
   logic [3:0]  nt_s_sel;
   logic [1:0]  nt_grant;

   wishbone_2mst_arbiter #(.TO_W(8), .TIMEOUT(8'd16), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_m0_cyc_i(m0_cyc), .wbs_m0_stb_i(m0_stb), .wbs_m0_we_i(m0_we),
      .wbs_m0_adr_i(m0_adr), .wbs_m0_dat_i(m0_wdat), .wbs_m0_sel_i(m0_sel),
      .wbs_m0_dat_o(m0_rdat), .wbs_m0_ack_o(m0_ack),
      .wbs_m1_cyc_i(m1_cyc), .wbs_m1_stb_i(m1_stb), .wbs_m1_we_i(m1_we),
      .wbs_m1_adr_i(m1_adr), .wbs_m1_dat_i(m1_wdat), .wbs_m1_sel_i(m1_sel),
      .wbs_m1_dat_o(m1_rdat), .wbs_m1_ack_o(m1_ack),
      .wbs_s_cyc_o(s_cyc), .wbs_s_stb_o(s_stb), .wbs_s_we_o(s_we),
      .wbs_s_adr_o(s_adr), .wbs_s_dat_o(s_wdat), .wbs_s_sel_o(s_sel),
      .wbs_s_dat_i(s_rdat), .wbs_s_ack_i(s_ack),
      .grant_o(grant), .timeout_o(tmo)
   );

   wishbone_2mst_arbiter #(.TO_W(8), .TIMEOUT(8'd0), .ERR_DATA(32'hDEAD_BEEF)) dut_nt (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_m0_cyc_i(nt_cyc), .wbs_m0_stb_i(nt_cyc), .wbs_m0_we_i(1'b0),
      .wbs_m0_adr_i(32'h3001_0400), .wbs_m0_dat_i(32'h0), .wbs_m0_sel_i(4'hF),
      .wbs_m0_dat_o(nt_m0_rdat), .wbs_m0_ack_o(nt_m0_ack),
      .wbs_m1_cyc_i(1'b0), .wbs_m1_stb_i(1'b0), .wbs_m1_we_i(1'b0),
      .wbs_m1_adr_i(32'h0), .wbs_m1_dat_i(32'h0), .wbs_m1_sel_i(4'h0),
      .wbs_m1_dat_o(nt_m1_rdat), .wbs_m1_ack_o(nt_m1_ack),
      .wbs_s_cyc_o(nt_s_cyc), .wbs_s_stb_o(nt_s_stb), .wbs_s_we_o(nt_s_we),
      .wbs_s_adr_o(nt_s_adr), .wbs_s_dat_o(nt_s_wdat), .wbs_s_sel_o(nt_s_sel),
      .wbs_s_dat_i(s_rdat), .wbs_s_ack_i(1'b0),
      .grant_o(nt_grant), .timeout_o(nt_tmo)
   );

   int n_vec = 0;
   int n_err = 0;
   int to_cnt = 0;

   typedef struct packed {
      logic [1:0]  who;
      logic [31:0] dat;
      logic [1:0]  gnt;
      logic        to;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_ack(input logic [1:0] who, input logic [31:0] dat, input logic [1:0] gnt, input logic to);
      exp_t e;
      e.who = who; e.dat = dat; e.gnt = gnt; e.to = to;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] idle_bus();
      return s_adr | s_wdat | m0_rdat | m1_rdat |
             {23'b0, s_sel, s_cyc, s_stb, s_we, m0_ack, m1_ack};
   endfunction

   function automatic logic [31:0] nt_idle_bus();
      return nt_s_adr | nt_s_wdat | nt_m0_rdat | nt_m1_rdat |
             {21'b0, nt_grant, nt_s_sel, nt_s_cyc, nt_s_stb, nt_s_we, nt_m0_ack, nt_m1_ack, nt_tmo};
   endfunction

   // Monitor: every ack presented to a master is matched against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (m0_ack || m1_ack)) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack: got acks %b expected none", {m1_ack, m0_ack});
         end else begin
            e = sb.pop_front();
            check("ack_who", {30'b0, m1_ack, m0_ack}, {30'b0, e.who});
            check("ack_dat", m1_ack ? m1_rdat : m0_rdat, e.dat);
            check("ack_gnt", {30'b0, grant}, {30'b0, e.gnt});
            check("ack_tmo", {31'b0, tmo}, {31'b0, e.to});
         end
      end
   end

   always @(negedge clk) begin
      if (tmo === 1'b1) to_cnt++;
   end

   // Slave model: acks after slv_wait wait states of an active cycle; negative never acks
   int          slv_wait  = 0;
   int          slv_cnt   = 0;
   bit          slv_fixed = 1'b0;
   logic [31:0] slv_data  = 32'hCAFE_F00D;
   always @(posedge clk) begin
      #2;
      s_ack  = 1'b0;
      s_rdat = slv_data;
      if (rst || !s_cyc || slv_wait < 0) begin
         slv_cnt = 0;
      end else if (slv_cnt == slv_wait) begin
         s_ack   = 1'b1;
         s_rdat  = slv_fixed ? slv_data : {s_adr[15:0], s_adr[31:16]};
         slv_cnt = 0;
      end else begin
         slv_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_set(input int m, input logic cyc, input logic [31:0] adr, input logic we,
                        input logic [31:0] wdat, input logic [3:0] sel);
      if (m == 0) begin
         m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_adr = adr; m0_wdat = wdat; m0_sel = sel;
      end else begin
         m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_adr = adr; m1_wdat = wdat; m1_sel = sel;
      end
   endtask

   task automatic wait_ack(input string name, input logic [1:0] who);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (({m1_ack, m0_ack} & who) != 2'b00) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL %s: got no ack in 64 cycles expected ack on %b", name, who);
   endtask

   // Counts cycles of s_cyc until m0 acks; checks the slave strobe in the ack cycle
   task automatic run_m0_until_ack(input string name, input logic exp_stb, output int cyc_n);
      cyc_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (s_cyc) cyc_n++;
         if (m0_ack) begin
            check({name, "_stb"}, {31'b0, s_stb}, {31'b0, exp_stb});
            return;
         end
      end
   endtask

   initial begin
      int cyc_n;
      int to_before;
      int nt_acks;
      int nt_tos;

      rst = 1'b1;
      nt_cyc = 1'b0;
      m_set(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      m_set(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

      // reset state
      tick(); tick();
      @(negedge clk);
      check("rst_grant", {30'b0, grant}, 32'h0);
      check("rst_tmo", {31'b0, tmo}, 32'h0);
      check("rst_outs", idle_bus(), 32'h0);
      check("rst_nt_outs", nt_idle_bus(), 32'h0);
      tick();
      rst = 1'b0;

      // single M0 read, two wait states
      tick();
      slv_wait = 2; slv_fixed = 1'b1; slv_data = 32'h1234_5678;
      m_set(0, 1'b1, 32'h3001_0000, 1'b0, 32'h0, 4'hF);
      expect_ack(2'b01, 32'h1234_5678, 2'b01, 1'b0);
      @(negedge clk);
      check("t1_lat_cyc", {31'b0, s_cyc}, 32'h0);
      check("t1_lat_grant", {30'b0, grant}, 32'h0);
      @(negedge clk);
      check("t1_cyc", {31'b0, s_cyc}, 32'h1);
      check("t1_grant", {30'b0, grant}, 32'h1);
      check("t1_adr", s_adr, 32'h3001_0000);
      wait_ack("t1_ack", 2'b01);
      tick();
      m_set(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      slv_fixed = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t1_release", {30'b0, grant}, 32'h0);

      // simultaneous request after reset: M0 first, then M1 back-to-back
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      slv_wait = 0;
      tick();
      m_set(0, 1'b1, 32'h3000_0004, 1'b0, 32'h0, 4'hF);
      m_set(1, 1'b1, 32'h3002_0008, 1'b1, 32'h5555_AAAA, 4'hC);
      expect_ack(2'b01, 32'h0004_3000, 2'b01, 1'b0);
      expect_ack(2'b10, 32'h0008_3002, 2'b10, 1'b0);
      wait_ack("t2_m0", 2'b01);
      tick();
      m_set(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      @(negedge clk);
      check("t2_hold_grant", {30'b0, grant}, 32'h1);
      @(negedge clk);
      check("t2_handover", {30'b0, grant}, 32'h2);
      check("t2_we", {31'b0, s_we}, 32'h1);
      check("t2_wdat", s_wdat, 32'h5555_AAAA);
      check("t2_sel", {28'b0, s_sel}, 32'hC);
      check("t2_adr", s_adr, 32'h3002_0008);
      tick();
      m_set(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

      // repeated ties: loser withdraws, winner must alternate
      slv_wait = 1;
      for (int r = 0; r < 4; r++) begin
         tick();
         m_set(0, 1'b1, 32'h3000_0010, 1'b0, 32'h0, 4'hF);
         m_set(1, 1'b1, 32'h3003_0020, 1'b0, 32'h0, 4'hF);
         if (r % 2 == 0) expect_ack(2'b01, 32'h0010_3000, 2'b01, 1'b0);
         else            expect_ack(2'b10, 32'h0020_3003, 2'b10, 1'b0);
         wait_ack("t3_ack", 2'b11);
         tick();
         m_set(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
         m_set(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      end

      // watchdog fires on the 16th unacked cycle
      tick();
      slv_wait = -1;
      to_before = to_cnt;
      m_set(0, 1'b1, 32'h3001_0040, 1'b0, 32'h0, 4'hF);
      expect_ack(2'b01, 32'hDEAD_BEEF, 2'b01, 1'b1);
      run_m0_until_ack("t4", 1'b0, cyc_n);
      check("t4_cycles", cyc_n, 32'd16);
      tick();
      m_set(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      tick(); tick();
      check("t4_to_pulses", to_cnt - to_before, 32'd1);

      // slave ack on the exact timeout cycle wins
      tick();
      slv_wait = 15; slv_fixed = 1'b1; slv_data = 32'h600D_DA7A;
      to_before = to_cnt;
      m_set(0, 1'b1, 32'h3001_0080, 1'b0, 32'h0, 4'hF);
      expect_ack(2'b01, 32'h600D_DA7A, 2'b01, 1'b0);
      run_m0_until_ack("t5", 1'b1, cyc_n);
      check("t5_cycles", cyc_n, 32'd16);
      tick();
      m_set(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      tick(); tick();
      check("t5_to_pulses", to_cnt - to_before, 32'd0);

      // TIMEOUT=0 instance never forces an ack
      tick();
      nt_cyc = 1'b1;
      nt_acks = 0;
      nt_tos = 0;
      repeat (1000) begin
         @(negedge clk);
         if (nt_m0_ack) nt_acks++;
         if (nt_tmo) nt_tos++;
      end
      check("t6_nt_acks", nt_acks, 32'd0);
      check("t6_nt_tmo", nt_tos, 32'd0);
      check("t6_nt_stb", {31'b0, nt_s_stb}, 32'h1);
      check("t6_nt_grant", {30'b0, nt_grant}, 32'h1);
      tick();
      nt_cyc = 1'b0;

      // reset during an M1 wait state; M0 wins the tie afterwards
      tick();
      slv_wait = -1; slv_fixed = 1'b0;
      m_set(1, 1'b1, 32'h3002_0100, 1'b0, 32'h0, 4'hF);
      repeat (4) @(negedge clk);
      check("t7_m1_own", {30'b0, grant}, 32'h2);
      tick();
      rst = 1'b1;
      m_set(0, 1'b1, 32'h3000_0200, 1'b0, 32'h0, 4'hF);
      tick();
      rst = 1'b0;
      slv_wait = 1;
      expect_ack(2'b01, 32'h0200_3000, 2'b01, 1'b0);
      @(negedge clk);
      check("t7_rst_grant", {30'b0, grant}, 32'h0);
      check("t7_rst_outs", idle_bus(), 32'h0);
      check("t7_rst_tmo", {31'b0, tmo}, 32'h0);
      @(negedge clk);
      check("t7_m0_grant", {30'b0, grant}, 32'h1);
      wait_ack("t7_ack", 2'b01);
      tick();
      m_set(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      m_set(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      tick(); tick();
      check("t7_idle", {30'b0, grant}, 32'h0);

      check("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
